// File: rtl/tpg_clocked_video_gen.sv
// Clocked-video test-pattern generator (bars / grey ramp / checker / flat grey); define TPG_BORDER_EN for a red border.
// Latency: every output is registered, one cycle behind the h/v counters.
// Backpressure: none; free-running stream, pattern select is applied only at the frame wrap.
module tpg_clocked_video_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1,
    parameter int CHK_LOG2 = 5
) (
    input  logic        vid_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  pattern_sel,
    output logic [23:0] vid_data,
    output logic        vid_datavalid,
    output logic        vid_h_sync,
    output logic        vid_v_sync,
    output logic        vid_f,
    output logic        vid_locked
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [1:0]    sync1_q, sync2_q, pat_q, pat_d;
    logic [23:0]   data_q, data_d;
    logic          dv_q, dv_d, hs_q, hs_d, vs_q, vs_d, locked_q, locked_d;
    logic          h_last, frame_wrap, active;
    logic [23:0]   bar_rgb, pix;
    logic [7:0]    ramp;

    always_comb begin
        h_last     = (int'(h_cnt_q) == H_TOTAL - 1);
        frame_wrap = h_last && (int'(v_cnt_q) == V_TOTAL - 1);
        active     = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);

        h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = frame_wrap ? '0 : v_cnt_q + 1'b1;
        end

        // Bar position tracks h_cnt incrementally so no divider is needed.
        bar_cnt_d = '0;
        bar_idx_d = '0;
        if (int'(h_cnt_q) < H_ACTIVE) begin
            if (int'(bar_cnt_q) == BAR_W - 1) begin
                bar_idx_d = bar_idx_q + 1'b1;
            end else begin
                bar_cnt_d = bar_cnt_q + 1'b1;
                bar_idx_d = bar_idx_q;
            end
        end

        case (bar_idx_q)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase

        ramp = 8'(h_cnt_q);
        case (pat_q)
            2'd0:    pix = bar_rgb;
            2'd1:    pix = {ramp, ramp, ramp};
            2'd2:    pix = (h_cnt_q[CHK_LOG2] ^ v_cnt_q[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
            default: pix = 24'h808080;
        endcase
`ifdef TPG_BORDER_EN
        if ((int'(h_cnt_q) == 0) || (int'(h_cnt_q) == H_ACTIVE - 1) ||
            (int'(v_cnt_q) == 0) || (int'(v_cnt_q) == V_ACTIVE - 1)) begin
            pix = 24'hFF0000;
        end
`else
`endif

        data_d   = active ? pix : 24'h000000;
        dv_d     = active;
        hs_d     = ((int'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                    (int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC)) ? SYNC_POL : ~SYNC_POL;
        vs_d     = ((int'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                    (int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC)) ? SYNC_POL : ~SYNC_POL;
        pat_d    = frame_wrap ? sync2_q : pat_q;
        locked_d = locked_q | frame_wrap;
    end

    always_ff @(posedge vid_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            pat_q     <= '0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            locked_q  <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            sync1_q   <= pattern_sel;
            sync2_q   <= sync1_q;
            pat_q     <= pat_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            locked_q  <= locked_d;
        end
    end

    assign vid_data      = data_q;
    assign vid_datavalid = dv_q;
    assign vid_h_sync    = hs_q;
    assign vid_v_sync    = vs_q;
    assign vid_f         = 1'b0;
    assign vid_locked    = locked_q;
endmodule

// File: tb/tb_tpg_clocked_video_gen.sv
// Scoreboard bench for tpg_clocked_video_gen on a 22x7 raster (frame = 154 clocks).
// Expected items are keyed by the number of clock edges since reset release.
module tb_tpg_clocked_video_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  psel = 2'd0;
    logic [23:0] vid_data;
    logic        vid_datavalid, vid_h_sync, vid_v_sync, vid_f, vid_locked;

    always #5 clk = ~clk;

    tpg_clocked_video_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .CHK_LOG2(1)
    ) dut (
        .vid_clk       (clk),
        .reset_reset_n (rst_n),
        .pattern_sel   (psel),
        .vid_data      (vid_data),
        .vid_datavalid (vid_datavalid),
        .vid_h_sync    (vid_h_sync),
        .vid_v_sync    (vid_v_sync),
        .vid_f         (vid_f),
        .vid_locked    (vid_locked)
    );

    localparam int S_DATA = 0, S_DV = 1, S_HS = 2, S_VS = 3, S_LOCK = 4, S_F = 5;

    typedef struct {
        int          cyc;
        int          sig;
        logic [23:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

`ifdef TPG_BORDER_EN
    localparam logic [23:0] RESTART_P0 = 24'hFF0000;
    localparam logic [23:0] RESTART_P2 = 24'hFF0000;
`else
    localparam logic [23:0] RESTART_P0 = 24'hFFFFFF;
    localparam logic [23:0] RESTART_P2 = 24'hFFFF00;
`endif

    // Insert keeping the queue ordered by cycle; equal cycles keep push order.
    task automatic push(input int c, input int s, input logic [23:0] v, input string nm);
        int pos;
        exp_t e;
        e.cyc = c; e.sig = s; e.val = v; e.name = nm;
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    function automatic logic [23:0] observe(input int s);
        case (s)
            S_DATA:  return vid_data;
            S_DV:    return {23'd0, vid_datavalid};
            S_HS:    return {23'd0, vid_h_sync};
            S_VS:    return {23'd0, vid_v_sync};
            S_LOCK:  return {23'd0, vid_locked};
            default: return {23'd0, vid_f};
        endcase
    endfunction

    // Monitor: count edges on posedge, compare due items on negedge.
    always @(clk) begin
        if (clk) begin
            if (rst_n) cyc++;
        end else begin
            exp_t e;
            logic [23:0] got;
            if (!rst_n) cyc = 0;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                got = observe(e.sig);
                n_chk++;
                if (e.cyc < cyc) begin
                    n_fail++;
                    $display("FAIL %s: item for cycle %0d not checked in time (now %0d)", e.name, e.cyc, cyc);
                end else if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %h expected %h", e.name, cyc, got, e.val);
                end
            end
        end
    end

    logic [23:0] bars [8];

    initial begin
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
`ifdef TPG_BORDER_EN
        psel = 2'd3;
`endif
        // Reset held.
        push(0, S_DATA, 24'h0, "rst_data");
        push(0, S_DV,   24'h0, "rst_dv");
        push(0, S_HS,   24'h0, "rst_hsync");
        push(0, S_VS,   24'h0, "rst_vsync");
        push(0, S_LOCK, 24'h0, "rst_locked");
        push(0, S_F,    24'h0, "rst_field");

        // Line 0 timing: datavalid edges 1..16, h_sync edges 19..20.
        for (int n = 1; n <= 22; n++) begin
            push(n, S_DV, {23'd0, (n <= 16)}, "line0_dv");
            push(n, S_HS, {23'd0, (n == 19 || n == 20)}, "line0_hsync");
        end
        // v_sync covers line 5 = edges 111..132.
        for (int n = 100; n <= 140; n++) begin
            push(n, S_VS, {23'd0, (n >= 111 && n <= 132)}, "vsync_line5");
        end
        // Frame period 154 and locked timing.
        push(1,   S_LOCK, 24'h0, "locked_early");
        push(153, S_LOCK, 24'h0, "locked_pre_wrap");
        push(154, S_DV,   24'h0, "frame_end_dv");
        push(154, S_LOCK, 24'h1, "locked_post_wrap");
        push(155, S_DV,   24'h1, "frame1_start_dv");
        push(200, S_F,    24'h0, "field_const");
        // Frame 2, line 2, pixel 3: just before the mid-frame reset.
        push(356, S_DV,   24'h1, "pre_reset_dv");
        push(356, S_LOCK, 24'h1, "pre_reset_locked");

`ifdef TPG_BORDER_EN
        push(1,   S_DATA, 24'hFF0000, "border_bars_p00");
        push(177, S_DATA, 24'hFF0000, "border_p0_1");
        push(182, S_DATA, 24'h808080, "grey_p5_1");
        push(192, S_DATA, 24'hFF0000, "border_p15_1");
        for (int n = 221; n <= 236; n++) begin
            push(n, S_DATA, 24'hFF0000, "border_line3");
        end
`else
        for (int n = 1; n <= 16; n++) begin
            push(n, S_DATA, bars[(n - 1) / 2], "bars_line0");
        end
        push(45,  S_DATA, 24'hFFFFFF, "bars_after_sel_p0_2");
        push(82,  S_DATA, 24'h000000, "bars_after_sel_p15_3");
        push(155, S_DATA, 24'h000000, "chk_p0_0");
        push(157, S_DATA, 24'hFFFFFF, "chk_p2_0");
        push(199, S_DATA, 24'hFFFFFF, "chk_p0_2");
`endif

        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef TPG_BORDER_EN
        // Switch to checkerboard in the middle of line 1.
        repeat (400) begin
            @(posedge clk); #1;
            if (cyc >= 30) break;
        end
        @(negedge clk);
        psel = 2'd2;
`endif

        repeat (500) begin
            @(posedge clk); #1;
            if (cyc >= 357) break;
        end
        n_chk++;
        if (cyc != 357) begin
            n_fail++;
            $display("FAIL reach_reset_point: cycle %0d expected 357", cyc);
        end
        // Asynchronous reset mid-line; outputs must drop before the next edge.
        rst_n = 1'b0;
        push(0, S_LOCK, 24'h0, "midreset_locked");
        push(0, S_DV,   24'h0, "midreset_dv");
        push(0, S_DATA, 24'h0, "midreset_data");
        push(1, S_DV,   24'h1, "restart_dv");
        push(1, S_DATA, RESTART_P0, "restart_p0");
        push(1, S_LOCK, 24'h0, "restart_locked");
        push(3, S_DATA, RESTART_P2, "restart_p2");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (50) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        @(negedge clk); #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d items left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tpg_clocked_video_gen.md
# tpg_clocked_video_gen

Test-pattern generator that synthesises a complete clocked-video stream: pixel data plus datavalid, h_sync, v_sync, field and locked. It sits directly upstream of the clocked-video-input (CTI) port of mySystem and drives its vid_* inputs from the same vid_clk. The pattern is selected by the 2-bit pio_0 export, so software can switch patterns at run time. Output changes take effect only on frame boundaries.

## Interface
- H_ACTIVE, 1280: active pixels per line; must be a multiple of 8.
- H_FP, 110: horizontal front porch, in pixels.
- H_SYNC, 40: h_sync width, in pixels.
- H_BP, 220: horizontal back porch, in pixels.
- V_ACTIVE, 720: active lines per frame.
- V_FP, 5 / V_SYNC, 5 / V_BP, 20: vertical porches and sync width, in lines.
- SYNC_POL, 1: sync asserted level (1 = active-high).
- CHK_LOG2, 5: checkerboard square size is 2^CHK_LOG2 pixels.
- vid_clk  in  1  pixel clock; the only clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- pattern_sel  in  2  pattern select from pio_0 export; asynchronous to vid_clk.
- vid_data  out  24  pixel {R[23:16],G[15:8],B[7:0]}.
- vid_datavalid  out  1  high on active pixels.
- vid_h_sync  out  1  horizontal sync.
- vid_v_sync  out  1  vertical sync.
- vid_f  out  1  field; tied 0 (progressive only).
- vid_locked  out  1  stream stable.

## Operation
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL is the vertical equivalent.
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0, incrementing v_cnt.
  - v_cnt runs 0..V_TOTAL-1 and wraps to 0.
  - Each line and each frame is ordered: active, FP, sync, BP.
- Decode:
  - Active region: h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - h_sync asserted for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - v_sync asserted for whole lines with V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC.
- pattern_sel synchronisation:
  - pattern_sel passes through a 2-flop synchroniser.
  - The synchronised value loads pat_reg only on the frame-wrap cycle (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1).
  - The pattern therefore never changes mid-frame.
- Patterns (pat_reg):
  - 0: colour bars, 8 bars each H_ACTIVE/8 wide. Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Use a bar counter and bar index, not a divider.
  - 1: grey ramp, R=G=B=h_cnt[7:0].
  - 2: checkerboard, h_cnt[CHK_LOG2]^v_cnt[CHK_LOG2] ? FFFFFF : 000000.
  - 3: solid 808080.
- vid_data is 000000 whenever the pixel is not active.
- Locked: vid_locked rises on the first frame-wrap after reset and stays high until reset.
- vid_f is constant 0.

## Timing
- Reset state (asynchronous, immediate):
  - h_cnt=0, v_cnt=0, pat_reg=0, synchroniser=0.
  - vid_data=0, vid_datavalid=0, vid_locked=0, vid_f=0.
  - vid_h_sync=vid_v_sync=!SYNC_POL.
- Latency: all outputs are registered and reflect the counter values of the previous cycle (1-cycle latency).
  - The first active pixel (0,0) appears on the first edge after reset release.
- Simple timing: a line lasts H_TOTAL cycles and a frame lasts H_TOTAL*V_TOTAL cycles; jitter is not permitted.
- pattern_sel latency: a change takes effect on the first frame that starts ≥3 cycles after the change.
- Coincident events: a pattern change arriving on the frame-wrap cycle itself applies only if it is already synchronised.
- Reset mid-frame: all outputs return to their reset values at once, and the counters restart at (0,0).

## Configuration
- TPG_BORDER_EN defined: active pixels with h_cnt∈{0,H_ACTIVE-1} or v_cnt∈{0,V_ACTIVE-1} are forced to FF0000. This override applies on top of every pattern.
- TPG_BORDER_EN undefined: no border logic is built, and the pattern fills the entire active area.

## Test plan
Parameters for the bench: H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=22); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7); SYNC_POL=1; CHK_LOG2=1.
- Reset held, then released:
  - While held, outputs are 0, syncs are 0 and locked is 0.
  - The first edge after release gives datavalid=1 with data=FFFFFF.
- Timing check:
  - 16 datavalid cycles per line.
  - h_sync high for 2 cycles starting 18 cycles after datavalid rises.
  - v_sync high for 22 cycles during line 5.
  - Frame period is 154 cycles.
- pattern_sel=0, pixels 0..15 of line 0 read pairwise FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- pattern_sel switched to 2 during line 1:
  - The rest of the frame remains bars.
  - In the next frame, pixel (0,0)=000000, (2,0)=FFFFFF, (0,2)=FFFFFF.
- Locked and mid-frame reset:
  - vid_locked=0 for the first 154 cycles and 1 from cycle 155.
  - Asserting reset at line 2 drops locked and datavalid within the same cycle.
  - After release, line 0 restarts.
- TPG_BORDER_EN defined, pattern_sel=3:
  - Pixel (0,1) and pixel (15,1) = FF0000.
  - Pixel (5,1)=808080.
  - Every pixel of line 3 = FF0000.
